// File: rtl/fifo_axis_pkg.sv
// Shared types for the AXIS transmitter: output-buffer depth, pointer/count types
// and the modulo-3 pointer step.
package fifo_axis_pkg;

    localparam int BUF_DEPTH = 3;

    typedef logic [1:0] buf_ptr_t;
    typedef logic [1:0] buf_cnt_t;

    // The buffer is 3 deep, so 2-bit pointers must wrap 2 -> 0 explicitly.
    function automatic buf_ptr_t ptr_next(input buf_ptr_t p);
        return (p == buf_ptr_t'(BUF_DEPTH - 1)) ? '0 : p + buf_ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_axis_tx_if.sv
// AXI-Stream channel between the transmitter and its downstream consumer.
interface fifo_axis_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fifo_axis_tx_out_buf.sv
// 3-entry circular output buffer; head entry drives the stream, occupancy gates reads.
module axis_out_buf
    import fifo_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output buf_cnt_t              o_occ
);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    buf_ptr_t              r_head;
    buf_ptr_t              r_tail;
    buf_cnt_t              r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_data;
                r_tail        <= ptr_next(r_tail);
            end
            if (i_pop) begin
                r_head <= ptr_next(r_head);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + buf_cnt_t'(1);
                2'b01:   r_occ <= r_occ - buf_cnt_t'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head_data = r_mem[r_head];
    assign o_occ       = r_occ;

endmodule

// File: rtl/fifo_axis_tx.sv
// AXIS transmitter on the FIFO read side: issues FIFO pops from registered state,
// buffers words, and emits them as an AXI-Stream with tlast every PKT_LEN beats.
module fifo_axis_tx
    import fifo_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    fifo_axis_tx_if.master        m_axis
);

    localparam int                CNT_W     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(PKT_LEN - 1);

    logic                  r_inflight;
    logic [CNT_W-1:0]      r_beat_cnt;
    buf_cnt_t              w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_room;
    logic                  w_tvalid;
    logic                  w_pop;
    logic                  w_last_beat;

    // Room counts the word already in flight so a capture never hits a full buffer;
    // tready is deliberately kept out of this path.
    assign w_room     = ({1'b0, w_occ} + {2'b00, r_inflight}) < 3'(BUF_DEPTH);
    assign fifo_rd_en = en & ~fifo_empty & ~rst & w_room;

    assign w_tvalid    = (w_occ != '0);
    assign w_pop       = w_tvalid & m_axis.tready;
    assign w_last_beat = (r_beat_cnt == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_pop) begin
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + CNT_W'(1);
            end
        end
    end

    axis_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (fifo_rd_data),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_occ       (w_occ)
    );

    assign m_axis.tdata  = w_head;
    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tlast  = w_tvalid & w_last_beat;

endmodule

// File: tb/tb_fifo_axis_tx.sv
// Bench for fifo_axis_tx: FIFO model feeding a PKT_LEN=16 and a PKT_LEN=1 instance,
// in-order scoreboard with beat-index tlast model and AXIS stability checks.
module tb_fifo_axis_tx;

    localparam int DW  = 32;
    localparam int PKT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          tready;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic          rd_en_b;

    fifo_axis_tx_if #(.DATA_WIDTH(DW)) ax16 ();
    fifo_axis_tx_if #(.DATA_WIDTH(DW)) ax1 ();
    assign ax16.tready = tready;
    assign ax1.tready  = tready;

    fifo_axis_tx #(.DATA_WIDTH(DW), .PKT_LEN(PKT)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m_axis       (ax16)
    );

    fifo_axis_tx #(.DATA_WIDTH(DW), .PKT_LEN(1)) dut_p1 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (rd_en_b),
        .m_axis       (ax1)
    );

    always #5 clk = ~clk;

    // Source FIFO: data appears one clock after the pop strobe; reset flushes it.
    logic [DW-1:0] fmem [0:4095];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= fmem[rd_ptr[11:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] sbq[$];
    int            beat = 0;
    int            outstanding = 0;
    int            last_tlast = -1;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int            cyc = 0;
    int            beats, rd_cnt, tlast_cnt, first_rd, first_vld, first_beat, last_beat;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        fmem[wr_ptr[11:0]] = w;
        wr_ptr++;
        sbq.push_back(w);
    endtask

    task automatic clear_stats();
        beats = 0; rd_cnt = 0; tlast_cnt = 0;
        first_rd = -1; first_vld = -1; first_beat = -1; last_beat = -1;
    endtask

    // Sample on the falling edge, then return 1 time unit after the next rising edge.
    task automatic tick();
        logic          xfer;
        logic [DW-1:0] exp;
        @(negedge clk);
        cyc++;
        if (rst) begin
            sbq.delete();
            beat        = 0;
            outstanding = 0;
            last_tlast  = -1;
            prev_stall  = 1'b0;
        end else begin
            xfer = ax16.tvalid & tready;
            chk("rd_en_p1_match", rd_en_b, fifo_rd_en);
            if (prev_stall) begin
                chk("stable_tvalid", ax16.tvalid, 1'b1);
                chk("stable_tdata", ax16.tdata, prev_data);
                chk("stable_tlast", ax16.tlast, prev_last);
            end
            if (!ax16.tvalid) chk("tlast_idle", ax16.tlast, 1'b0);
            if (fifo_rd_en) begin
                chk("rd_when_empty", fifo_empty, 1'b0);
                if (first_rd < 0) first_rd = cyc;
                rd_cnt++;
            end
            if (ax16.tvalid && first_vld < 0) first_vld = cyc;
            if (xfer) begin
                chk("sb_nonempty", (sbq.size() != 0), 1'b1);
                exp = (sbq.size() != 0) ? sbq.pop_front() : 32'hDEAD_BEEF;
                chk("tdata", ax16.tdata, exp);
                chk("tlast", ax16.tlast, ((beat % PKT) == PKT - 1));
                if (ax1.tvalid) begin
                    chk("tdata_p1", ax1.tdata, exp);
                    chk("tlast_p1", ax1.tlast, 1'b1);
                end
                if (ax16.tlast) begin
                    if (last_tlast >= 0) chk("tlast_period", beat - last_tlast, PKT);
                    last_tlast = beat;
                    tlast_cnt++;
                end
                beat++;
                beats++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
            end
            outstanding += int'(fifo_rd_en) - int'(xfer);
            chk("occ_le3", (outstanding <= 3), 1'b1);
            prev_stall = ax16.tvalid & ~tready;
            prev_data  = ax16.tdata;
            prev_last  = ax16.tlast;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst = 1'b1; en = 1'b0; tready = 1'b0;
        clear_stats();
        tick(); tick();
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_tvalid", ax16.tvalid, 1'b0);
        chk("rst_tlast", ax16.tlast, 1'b0);
        chk("rst_tdata", ax16.tdata, '0);
        rst = 1'b0;
        tick();
        chk("post_rst_tvalid", ax16.tvalid, 1'b0);
        chk("post_rst_rd_en", fifo_rd_en, 1'b0);

        // Latency and full-rate burst
        clear_stats();
        for (int i = 1; i <= 32; i++) load(DW'(i));
        en = 1'b1; tready = 1'b1;
        for (int i = 0; i < 100 && beats < 32; i++) tick();
        chk("burst_beats", beats, 32);
        chk("burst_latency", first_vld - first_rd, 2);
        chk("burst_consecutive", last_beat - first_beat, 31);
        chk("burst_tlast_cnt", tlast_cnt, 2);

        // Backpressure
        clear_stats();
        for (int i = 0; i < 20; i++) load($urandom);
        repeat (5) tick();
        tready = 1'b0;
        repeat (10) tick();
        chk("bp_rd_stop", fifo_rd_en, 1'b0);
        chk("bp_occ_full", outstanding, 3);
        chk("bp_tvalid", ax16.tvalid, 1'b1);
        tready = 1'b1;
        for (int i = 0; i < 200 && sbq.size() != 0; i++) tick();
        chk("bp_drained", sbq.size(), 0);
        chk("bp_beats", beats, 20);

        // Random ready over 1000 words
        clear_stats();
        b0 = beat;
        for (int i = 0; i < 1000; i++) load($urandom);
        for (int i = 0; i < 6000 && sbq.size() != 0; i++) begin
            tready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("rand_drained", sbq.size(), 0);
        chk("rand_beats", beats, 1000);
        chk("rand_tlast_cnt", tlast_cnt, (b0 + 1000) / PKT - b0 / PKT);
        tready = 1'b1;
        repeat (3) tick();

        // FIFO goes empty while a word is in flight
        tready = 1'b0;
        clear_stats();
        load(32'hA5A5_0001);
        tick(); tick();
        chk("inflight_fifo_empty", fifo_empty, 1'b1);
        for (int i = 0; i < 5 && !ax16.tvalid; i++) tick();
        chk("inflight_tvalid", ax16.tvalid, 1'b1);
        chk("inflight_tdata", ax16.tdata, 32'hA5A5_0001);
        chk("inflight_reads", rd_cnt, 1);
        tready = 1'b1;
        repeat (3) tick();
        chk("inflight_beats", beats, 1);

        // en=0 with two words buffered
        tready = 1'b0;
        clear_stats();
        for (int i = 0; i < 5; i++) load($urandom);
        for (int i = 0; i < 10 && rd_cnt < 2; i++) tick();
        en = 1'b0;
        tick(); tick();
        chk("en0_buffered", outstanding, 2);
        clear_stats();
        tready = 1'b1;
        repeat (8) tick();
        chk("en0_beats", beats, 2);
        chk("en0_no_reads", rd_cnt, 0);
        chk("en0_tvalid", ax16.tvalid, 1'b0);

        // Reset mid-stream with two words buffered
        tready = 1'b0;
        clear_stats();
        en = 1'b1;
        for (int i = 0; i < 10 && rd_cnt < 2; i++) tick();
        en = 1'b0;
        tick(); tick();
        chk("mrst_pre_occ", outstanding, 2);
        rst = 1'b1;
        #1;
        chk("mrst_tvalid", ax16.tvalid, 1'b0);
        chk("mrst_tlast", ax16.tlast, 1'b0);
        chk("mrst_rd_en", fifo_rd_en, 1'b0);
        chk("mrst_tdata", ax16.tdata, '0);
        tick(); tick();
        rst = 1'b0;
        clear_stats();
        for (int i = 0; i < 17; i++) load(32'h5000_0000 + DW'(i));
        en = 1'b1; tready = 1'b1;
        for (int i = 0; i < 100 && beats < 17; i++) tick();
        chk("mrst_beats", beats, 17);
        chk("mrst_tlast_cnt", tlast_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
